// File: rtl/add_sub_chunked_pkg.sv
// Shared types and constants for the chunked add/subtract unit.
package add_sub_chunked_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_sub_chunked_if.sv
// Operand/result bus of the chunked add/subtract unit with start/busy/done handshake.
interface add_sub_chunked_if #(
  parameter int unsigned WIDTH = 8
);
  logic             enable;
  logic             start;
  logic             sub;
  logic             cIn;
  logic [WIDTH-1:0] dIn0;
  logic [WIDTH-1:0] dIn1;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dOut;
  logic             cOut;
  logic             overflow;
  logic             zero;

  modport master (
    output enable, start, sub, cIn, dIn0, dIn1,
    input  busy, done, dOut, cOut, overflow, zero
  );

  modport slave (
    input  enable, start, sub, cIn, dIn0, dIn1,
    output busy, done, dOut, cOut, overflow, zero
  );
endinterface

// File: rtl/add_sub_chunked_chunk_adder.sv
// CHUNK-bit ripple adder slice; also exposes the carry into its top bit for overflow detection.
module chunk_adder #(
  parameter int unsigned CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cIn,
  output logic [CHUNK-1:0] sum,
  output logic             cOut,
  output logic             cMsb
);
  logic [CHUNK:0] carry;

  // Full-adder cell chain
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cIn;
    for (int i = 0; i < int'(CHUNK); i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cOut = carry[CHUNK];
  assign cMsb = carry[CHUNK-1];

endmodule

// File: rtl/add_sub_chunked.sv
// Multi-cycle add/subtract: WIDTH-bit operands processed CHUNK bits per clock, LSB chunk first,
// with a registered carry between chunks and registered result/flags gated by enable.
module add_sub_chunked
  import add_sub_chunked_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input logic              clk,
  input logic              rstN,
  add_sub_chunked_if.slave bus
);
  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  state_t             state;
  state_t             stateNext;
  logic               accept;
  logic               step;
  logic               finish;

  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic               opSub;
  logic [WIDTH-1:0]   aSh;
  logic [WIDTH-1:0]   bSh;
  logic [WIDTH-1:0]   resSh;
  logic [WIDTH-1:0]   resNext;

  logic [CHUNK-1:0]   sumChunk;
  logic               chunkCout;
  logic               chunkCmsb;

  logic [WIDTH-1:0]   dOutQ;
  logic               cOutQ;
  logic               overflowQ;
  logic               zeroQ;

  chunk_adder #(.CHUNK(CHUNK)) u_chunkAdder (
    .a    (aSh[CHUNK-1:0]),
    .b    (bSh[CHUNK-1:0]),
    .cIn  (carry),
    .sum  (sumChunk),
    .cOut (chunkCout),
    .cMsb (chunkCmsb)
  );

  // Sum chunks enter at the top and shift down, so after N steps chunk k sits at k*CHUNK
  assign resNext = (resSh >> CHUNK) | (WIDTH'(sumChunk) << (WIDTH - CHUNK));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= stateNext;
  end

  // Next state and per-cycle control; everything holds while enable is low
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    if (bus.enable) begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            accept    = 1'b1;
            stateNext = RUN;
          end
        end
        RUN: begin
          step = 1'b1;
          if (cnt == CNT_W'(N - 1)) begin
            finish    = 1'b1;
            stateNext = DONE;
          end
        end
        DONE: begin
          if (bus.start) begin
            accept    = 1'b1;
            stateNext = RUN;
          end else begin
            stateNext = IDLE;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // Operand capture, chunk stepping and result/flag latching
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt       <= '0;
      carry     <= 1'b0;
      opSub     <= 1'b0;
      aSh       <= '0;
      bSh       <= '0;
      resSh     <= '0;
      dOutQ     <= '0;
      cOutQ     <= 1'b0;
      overflowQ <= 1'b0;
      zeroQ     <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      carry <= bus.cIn ^ bus.sub;
      opSub <= bus.sub;
      aSh   <= bus.dIn0;
      bSh   <= (bus.sub == OP_SUB) ? ~bus.dIn1 : bus.dIn1;
      resSh <= '0;
    end else if (step) begin
      aSh   <= aSh >> CHUNK;
      bSh   <= bSh >> CHUNK;
      carry <= chunkCout;
      resSh <= resNext;
      cnt   <= finish ? '0 : cnt + CNT_W'(1);
      if (finish) begin
        dOutQ     <= resNext;
        cOutQ     <= chunkCout ^ opSub;
        overflowQ <= chunkCmsb ^ chunkCout;
        zeroQ     <= (resNext == '0);
      end
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE) & bus.enable;
  assign bus.dOut     = dOutQ & {WIDTH{bus.enable}};
  assign bus.cOut     = cOutQ & bus.enable;
  assign bus.overflow = overflowQ & bus.enable;
  assign bus.zero     = zeroQ & bus.enable;

endmodule
